// File: rtl/tick_generator.sv
// rtl/tick_generator.sv - once-per-second tick plus debounced minutes/hours set pulses
// Buttons are synchronized and debounced; a three-state FSM selects time-keeping or set mode.
module tick_generator #(
  parameter int CLK_FREQ        = 32768,
  parameter int FAST_SET_HZ     = 8,
  parameter int DEBOUNCE_CYCLES = 64
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ena,
  input  logic btn_minutes,
  input  logic btn_hours,
  input  logic btn_fast,
  output logic sec_en,
  output logic min_set_en,
  output logic hr_set_en,
  output logic set_active
);

  localparam int FAST_DIV = CLK_FREQ / FAST_SET_HZ;
  localparam int CNT_W    = $clog2(CLK_FREQ);
  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [CNT_W-1:0] SEC_LAST  = CNT_W'(CLK_FREQ - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SET_MIN = 2'd1,
    SET_HR  = 2'd2
  } state_t;

  state_t state, next_state;

  logic [2:0]      btn_raw, sync_1, sync_2, db;
  logic [DB_W-1:0] db_cnt [3];
  logic            dm, dh, df, df_q;
  logic [CNT_W-1:0] sec_cnt, set_cnt, set_last;
  logic            set_tick;

  assign btn_raw  = {btn_fast, btn_hours, btn_minutes};
  assign dm       = db[0];
  assign dh       = db[1];
  assign df       = db[2];
  assign set_last = df ? FAST_LAST : SEC_LAST;

  // Two-flop synchronizer feeding a run-length debouncer per button.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      db     <= '0;
      for (int i = 0; i < 3; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_1 <= btn_raw;
      sync_2 <= sync_1;
      for (int i = 0; i < 3; i++) begin
        if (sync_2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync_2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Hours always win over minutes, including when both change together in SET_MIN.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (dh)      next_state = SET_HR;
        else if (dm) next_state = SET_MIN;
      end
      SET_MIN: begin
        if (dh)       next_state = SET_HR;
        else if (!dm) next_state = IDLE;
      end
      SET_HR: begin
        if (!dh) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    set_active = (state != IDLE);
    min_set_en = set_tick && (state == SET_MIN);
    hr_set_en  = set_tick && (state == SET_HR);
  end

  // Counting only while staying in IDLE keeps sec_en out of the first set cycle
  // and makes the first tick after a set land a full second later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_cnt <= '0;
      sec_en  <= 1'b0;
    end else if (state != IDLE || next_state != IDLE) begin
      sec_cnt <= '0;
      sec_en  <= 1'b0;
    end else if (ena) begin
      if (sec_cnt == SEC_LAST) begin
        sec_cnt <= '0;
        sec_en  <= 1'b1;
      end else begin
        sec_cnt <= sec_cnt + CNT_W'(1);
        sec_en  <= 1'b0;
      end
    end else begin
      sec_en <= 1'b0;
    end
  end

  // set_tick is registered against the next state so the entry pulse lands in the first set cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      set_cnt  <= '0;
      set_tick <= 1'b0;
      df_q     <= 1'b0;
    end else begin
      df_q <= df;
      if (next_state == IDLE) begin
        set_cnt  <= '0;
        set_tick <= 1'b0;
      end else if (next_state != state) begin
        set_cnt  <= '0;
        set_tick <= 1'b1;
      end else if (df != df_q) begin
        set_cnt  <= '0;
        set_tick <= 1'b0;
      end else if (set_cnt == set_last) begin
        set_cnt  <= '0;
        set_tick <= 1'b1;
      end else begin
        set_cnt  <= set_cnt + CNT_W'(1);
        set_tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_generator.sv
// tb/tb_tick_generator.sv - directed and randomized checks of tick_generator against a behavioural model
module tb_tick_generator;

  localparam int CF       = 10;
  localparam int FS       = 5;
  localparam int DB       = 4;
  localparam int FAST_DIV = CF / FS;
  localparam int HIST     = 8192;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ena = 1'b0;
  logic btn_minutes = 1'b0;
  logic btn_hours = 1'b0;
  logic btn_fast = 1'b0;
  logic sec_en, min_set_en, hr_set_en, set_active;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit sec_h [HIST];
  bit min_h [HIST];
  bit hr_h  [HIST];
  bit sa_h  [HIST];

  // Model: sample history, debounce run lengths, mode, elapsed-time bookkeeping.
  logic [2:0] m_samples [$];
  int         m_run [3];
  logic [2:0] m_db;
  int         m_mode;
  int         m_sec_ticks;
  int         m_origin;
  int         m_edge;
  logic       m_df_prev;
  logic       e_sec, e_min, e_hr, e_sa;

  tick_generator #(
    .CLK_FREQ(CF),
    .FAST_SET_HZ(FS),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ena(ena),
    .btn_minutes(btn_minutes),
    .btn_hours(btn_hours),
    .btn_fast(btn_fast),
    .sec_en(sec_en),
    .min_set_en(min_set_en),
    .hr_set_en(hr_set_en),
    .set_active(set_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_samples.delete();
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_db = '0;
    m_mode = 0;
    m_sec_ticks = 0;
    m_origin = 0;
    m_edge = 0;
    m_df_prev = 1'b0;
    {e_sec, e_min, e_hr, e_sa} = '0;
    cyc = 0;
    for (int i = 0; i < HIST; i++) begin
      sec_h[i] = 0; min_h[i] = 0; hr_h[i] = 0; sa_h[i] = 0;
    end
  endtask

  // One rising edge: every decision uses values from before the edge.
  task automatic model_step();
    logic [2:0] s2;
    int nxt, period;
    logic e_set;
    m_edge++;
    s2 = (m_samples.size() == 2) ? m_samples[0] : 3'b000;
    nxt = m_mode;
    if (m_mode == 0)      nxt = m_db[1] ? 2 : (m_db[0] ? 1 : 0);
    else if (m_mode == 1) nxt = m_db[1] ? 2 : (m_db[0] ? 1 : 0);
    else                  nxt = m_db[1] ? 2 : 0;

    e_sec = 1'b0;
    if (m_mode == 0 && nxt == 0) begin
      if (ena) begin
        m_sec_ticks++;
        e_sec = (m_sec_ticks % CF == 0);
      end
    end else begin
      m_sec_ticks = 0;
    end

    e_set = 1'b0;
    period = m_db[2] ? FAST_DIV : CF;
    if (nxt != 0) begin
      if (nxt != m_mode) begin
        m_origin = m_edge;
        e_set = 1'b1;
      end else if (m_db[2] != m_df_prev) begin
        m_origin = m_edge;
      end else begin
        e_set = ((m_edge - m_origin) % period == 0);
      end
    end
    e_min = e_set && nxt == 1;
    e_hr  = e_set && nxt == 2;
    e_sa  = (nxt != 0);
    m_df_prev = m_db[2];
    m_mode = nxt;

    for (int i = 0; i < 3; i++) begin
      if (s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_db[i] = s2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_samples.push_back({btn_fast, btn_hours, btn_minutes});
    if (m_samples.size() > 2) void'(m_samples.pop_front());
  endtask

  always @(posedge clk) begin
    if (reset_n) begin
      cyc++;
      model_step();
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      check("sec_en", sec_en, e_sec);
      check("min_set_en", min_set_en, e_min);
      check("hr_set_en", hr_set_en, e_hr);
      check("set_active", set_active, e_sa);
      check("one_pulse", (int'(sec_en) + int'(min_set_en) + int'(hr_set_en)) <= 1, 1);
      if (cyc < HIST) begin
        sec_h[cyc] = sec_en;
        min_h[cyc] = min_set_en;
        hr_h[cyc]  = hr_set_en;
        sa_h[cyc]  = set_active;
      end
    end
  end

  function automatic bit hist_at(input int which, input int c);
    if (c < 0 || c >= HIST) return 1'b0;
    case (which)
      0: return sec_h[c];
      1: return min_h[c];
      2: return hr_h[c];
      default: return sa_h[c];
    endcase
  endfunction

  function automatic int count_in(input int which, input int from, input int to);
    int n = 0;
    for (int c = from; c <= to; c++) n += int'(hist_at(which, c));
    return n;
  endfunction

  function automatic int first_at(input int which, input int from, input int to);
    for (int c = from; c <= to; c++) if (hist_at(which, c)) return c;
    return -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    check("rst_sec_en", sec_en, 0);
    check("rst_min_set_en", min_set_en, 0);
    check("rst_hr_set_en", hr_set_en, 0);
    check("rst_set_active", set_active, 0);
    model_reset();
    cycles(3);
    reset_n = 1'b1;
  endtask

  initial begin
    int t0, t1, r;
    cycles(2);
    apply_reset();
    ena = 1'b1;

    // Free-running seconds: pulses at cycles 10, 20, ... 100.
    cycles(100);
    check("sec_count_100", count_in(0, 1, 100), 10);
    for (int k = 1; k <= 10; k++) check("sec_at_k10", hist_at(0, 10 * k), 1);

    // Three-cycle glitch must be rejected by the debouncer.
    t0 = cyc;
    btn_minutes = 1'b1;
    cycles(3);
    btn_minutes = 1'b0;
    cycles(20);
    check("glitch_set_active", count_in(3, t0, cyc), 0);
    check("glitch_min_pulses", count_in(1, t0, cyc), 0);
    check("glitch_sec_110", hist_at(0, t0 + 10), 1);
    check("glitch_sec_120", hist_at(0, t0 + 20), 1);

    // Slow minutes set: 2 sync + 4 debounce + state register before set mode.
    t0 = cyc;
    btn_minutes = 1'b1;
    cycles(30);
    btn_minutes = 1'b0;
    cycles(20);
    check("min_entry", first_at(3, t0, cyc), t0 + 7);
    check("min_pulse_count", count_in(1, t0, cyc), 3);
    check("min_pulse_17", hist_at(1, t0 + 17), 1);
    check("min_pulse_27", hist_at(1, t0 + 27), 1);
    check("min_no_sec", count_in(0, t0 + 7, t0 + 36), 0);
    check("min_exit", hist_at(3, t0 + 37), 0);
    check("min_sec_after", first_at(0, t0 + 37, cyc), t0 + 47);

    // Fast hours set: pulses every FAST_DIV cycles.
    btn_fast = 1'b1;
    cycles(10);
    t1 = cyc;
    btn_hours = 1'b1;
    cycles(20);
    btn_hours = 1'b0;
    cycles(20);
    check("hr_entry_pulse", first_at(2, t1, cyc), t1 + 7);
    check("hr_pulse_count", count_in(2, t1, cyc), 10);
    check("hr_pulse_9", hist_at(2, t1 + 9), 1);
    check("hr_exit", hist_at(3, t1 + 27), 0);
    check("hr_sec_after", first_at(0, t1 + 27, cyc), t1 + 37);
    btn_fast = 1'b0;
    cycles(10);

    // Both buttons: hours wins; dropping hours passes through IDLE into SET_MIN.
    t0 = cyc;
    btn_minutes = 1'b1;
    btn_hours = 1'b1;
    cycles(20);
    t1 = cyc;
    btn_hours = 1'b0;
    cycles(20);
    btn_minutes = 1'b0;
    cycles(10);
    check("both_hr_pulse", hist_at(2, t0 + 7), 1);
    check("both_no_min", count_in(1, t0, t1 + 7), 0);
    check("both_still_set", hist_at(3, t1 + 6), 1);
    check("both_idle_gap", hist_at(3, t1 + 7), 0);
    check("both_min_entry", hist_at(1, t1 + 8), 1);

    // Reset during SET_MIN aborts it; counting restarts from zero.
    btn_minutes = 1'b1;
    cycles(12);
    check("pre_reset_set_active", set_active, 1);
    btn_minutes = 1'b0;
    apply_reset();
    cycles(12);
    check("post_reset_first_sec", first_at(0, 1, 12), 10);
    check("post_reset_set_active", count_in(3, 1, 12), 0);

    // Randomized segments, including glitches, ena gaps and resets with buttons held.
    for (int seg = 0; seg < 160; seg++) begin
      r = $urandom_range(0, 99);
      btn_minutes = ($urandom_range(0, 2) == 0);
      btn_hours   = ($urandom_range(0, 3) == 0);
      btn_fast    = ($urandom_range(0, 1) == 0);
      ena         = ($urandom_range(0, 4) != 0);
      if (r < 3) apply_reset();
      cycles($urandom_range(1, 30));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
